load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core datapath's memory port (ALU result as address, register rs2 as store data) and a variable-latency data memory.
- Formats byte, halfword and word loads and stores (RV32I funct3 encodings) and produces byte-lane strobes.
- Holds the core with a stall signal until the memory answers, so the single-cycle core can run against multi-cycle memory.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
- TIMEOUT_W, 8: width of the response watchdog counter (used only with the optional feature).
- TIMEOUT_MAX, 255: wait cycles in BUSY before aborting (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately
- req_valid  in  1  core has a memory op this cycle; fields below held stable while stall=1
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- stall  out  1  core must hold PC and request fields
- rsp_valid  out  1  one-cycle pulse: access complete, rsp_rdata/rsp_err valid
- rsp_rdata  out  32  extended load data (0 for stores and errors)
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout
- mem_req  out  1  request to memory, held until mem_ready
- mem_we  out  1  write enable
- mem_addr  out  32  word address: req_addr with bits [1:0] forced to 0
- mem_wstrb  out  4  byte-lane enables (0000 on loads)
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory accepts the write / returns read data this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1

Behaviour:
- Reset: state=IDLE; stall, rsp_valid, mem_req, mem_we all 0; mem_addr, mem_wstrb, mem_wdata, rsp_rdata, rsp_err all 0.
- Reset mid-BUSY drops mem_req at once; the memory must tolerate an abandoned request.
- States: IDLE, BUSY, DONE.
- stall = req_valid & (state != DONE), combinational.
- IDLE with req_valid=1 and a legal, aligned access:
  - latch we, funct3, addr[1:0]; drive mem_* registered; go to BUSY with mem_req=1.
- IDLE with req_valid=1 and an error:
  - errors are funct3 not in {000,001,010,100,101}, or a store with funct3 in {100,101}, or misalignment (h with addr[0]=1; w with addr[1:0]!=0).
  - go directly to DONE with the rsp_err code; mem_req stays 0.
- BUSY:
  - mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata stay constant until mem_ready=1.
  - On mem_ready: drop mem_req, capture the formatted read data, go to DONE.
- DONE: rsp_valid=1 and stall=0 for exactly one cycle, then IDLE. The core advances on this edge.
- A req_valid in the cycle after DONE is a new instruction and is accepted normally.
- Latency: with zero-wait memory (mem_ready high in the first BUSY cycle), the core stalls 2 cycles and completes on the 3rd. Each extra memory wait cycle adds one.
- Store lanes, with o = addr[1:0]:
  - sb: strb = 0001<<o; wdata = {4{wdata[7:0]}}.
  - sh: strb = 0011 (o=0) or 1100 (o=2); wdata = {2{wdata[15:0]}}.
  - sw: strb = 1111.
- Load extract (o = addr[1:0]):
  - byte = mem_rdata[8o+7:8o].
  - half = mem_rdata[16·o[1]+15 : 16·o[1]].
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word unchanged.
- rsp_rdata holds its value until the next capture; it is 0 after stores and errors.
- mem_ready while not in BUSY is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on BUSY entry and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT_MAX, drop mem_req, go to DONE with rsp_err=11 and rsp_rdata=0.
  - mem_ready arriving in the same cycle as the limit wins: normal completion.
- Not defined: no counter; BUSY waits indefinitely and rsp_err=11 is never produced.

Test Plan:
- lw addr=0x64, memory word 0x00000019, mem_ready in first BUSY cycle -> stall high 2 cycles, rsp_valid on 3rd cycle, rsp_rdata=0x00000019, rsp_err=00.
- sb addr=0x61, wdata=0x000000AB -> mem_addr=0x60, mem_wstrb=0010, mem_wdata=0xABABABAB, mem_we=1; then lb addr=0x61 with word 0x0000AB00 -> rsp_rdata=0xFFFFFFAB, and lbu of the same address -> 0x000000AB.
- lh addr=0x62, word 0x80010000, mem_ready delayed 4 cycles -> mem_req and mem_addr=0x60 stable all 4 cycles, rsp_rdata=0xFFFF8001, 6 total stall cycles.
- lw addr=0x66 -> mem_req never asserted, 1-cycle stall, rsp_err=01. req_funct3=011 load -> rsp_err=10. sh with funct3=101 -> rsp_err=10.
- reset driven to 0 mid-BUSY -> mem_req, stall, rsp_valid 0 immediately; after release, a new sw addr=0x100 wdata=0xDEADBEEF completes with strb=1111.
- With LSU_TIMEOUT_EN and TIMEOUT_MAX=4, mem_ready tied 0 -> mem_req drops after 4 BUSY cycles, rsp_valid with rsp_err=11, rsp_rdata=0. Without the macro -> stall remains high indefinitely.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store formatter with stall handshake to variable-latency memory.
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;

  logic        f3_legal;
  logic        misaligned;
  logic [1:0]  req_err;
  logic [3:0]  req_strb;
  logic [31:0] req_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request decode: illegal encoding takes priority over misalignment.
  always_comb begin
    f3_legal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~req_we;
      default:                f3_legal = 1'b0;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (!f3_legal)      req_err = ERR_FUNCT3;
    else if (misaligned) req_err = ERR_MISALIGN;
    else                req_err = ERR_OK;
  end

  always_comb begin
    req_strb  = 4'b0000;
    req_lanes = 32'd0;
    if (req_we) begin
      unique case (req_funct3[1:0])
        2'b00: begin
          req_strb  = 4'b0001 << req_addr[1:0];
          req_lanes = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          req_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
          req_lanes = {2{req_wdata[15:0]}};
        end
        default: begin
          req_strb  = 4'b1111;
          req_lanes = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = 8'd0;
    unique case (off_q)
      2'b00: ld_byte = mem_rdata[7:0];
      2'b01: ld_byte = mem_rdata[15:8];
      2'b10: ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout_hit;
  assign timeout_hit = (cnt_q == TIMEOUT_W'(TIMEOUT_MAX - 1));
`else
  logic unused_params;
  assign unused_params = (TIMEOUT_W != 0) ^ (TIMEOUT_MAX != 0);
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (req_err != ERR_OK) begin
            state_d     = DONE;
            rsp_err_d   = req_err;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d     = BUSY;
            rsp_err_d   = ERR_OK;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wstrb_d = req_strb;
            mem_wdata_d = req_lanes;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          rsp_rdata_d = we_q ? 32'd0 : ld_data;
`ifdef LSU_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wstrb_q <= 4'd0;
      mem_wdata_q <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= ERR_OK;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // The core is released in DONE so it advances on the completing edge.
  assign stall     = req_valid & (state_q != DONE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a scripted memory responder.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] word;
    int          waits;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  load_store_unit #(.TIMEOUT_W(8), .TIMEOUT_MAX(4)) dut (
`else
  load_store_unit dut (
`endif
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: checks request fields every BUSY cycle, answers after the scripted waits.
  initial begin
    mem_exp_t cur;
    int       wcnt;
    bit       active;
    active    = 1'b0;
    wcnt      = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    cur       = '{32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_ready = 1'b0;
        active    = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          wcnt   = 0;
          if (mem_q.size() == 0) begin
            check("unexpected mem_req", {31'd0, mem_req}, 32'd0);
            cur = '{mem_addr, mem_we, mem_wstrb, mem_wdata, 32'd0, 0};
          end else begin
            cur = mem_q.pop_front();
          end
        end
        check("mem_addr", mem_addr, cur.addr);
        check("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
        check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.strb});
        if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        if (wcnt == cur.waits) begin
          mem_ready = 1'b1;
          mem_rdata = cur.word;
        end else begin
          mem_ready = 1'b0;
        end
        wcnt++;
      end else begin
        mem_ready = 1'b0;
        active    = 1'b0;
      end
    end
  end

  // Response monitor
  initial begin
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (reset && rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
        end
      end
    end
  end

  task automatic do_op(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit uses_mem, input logic [3:0] strb, input logic [31:0] mwdata,
                       input logic [31:0] word, input int waits,
                       input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                       input int exp_stall);
    int n_stall;
    bit done;
    if (uses_mem) mem_q.push_back('{{addr[31:2], 2'b00}, we, strb, mwdata, word, waits});
    rsp_q.push_back('{exp_rdata, exp_err});
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n_stall    = 0;
    done       = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (rsp_valid) done = 1'b1;
    end
    if (!done) check({name, " completion timeout"}, 32'd0, 32'd1);
    check({name, " stall cycles"}, n_stall, exp_stall);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hang_cycles;
    int n;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (2) @(negedge clk);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", {30'd0, rsp_err}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    //    name     we   f3     addr          wdata         mem strb     mwdata        word          wt rdata         err    st
    do_op("lw",    0, 3'b010, 32'h64,  32'h0,        1, 4'b0000, 32'h0,        32'h00000019, 0, 32'h00000019, 2'b00, 2);
    do_op("sb",    1, 3'b000, 32'h61,  32'h000000AB, 1, 4'b0010, 32'hABABABAB, 32'h0,        0, 32'h0,        2'b00, 2);
    do_op("lb",    0, 3'b000, 32'h61,  32'h0,        1, 4'b0000, 32'h0,        32'h0000AB00, 0, 32'hFFFFFFAB, 2'b00, 2);
    do_op("lbu",   0, 3'b100, 32'h61,  32'h0,        1, 4'b0000, 32'h0,        32'h0000AB00, 0, 32'h000000AB, 2'b00, 2);
    do_op("lh",    0, 3'b001, 32'h62,  32'h0,        1, 4'b0000, 32'h0,        32'h80010000, 4, 32'hFFFF8001, 2'b00, 6);
    do_op("lhu",   0, 3'b101, 32'h62,  32'h0,        1, 4'b0000, 32'h0,        32'h80010000, 0, 32'h00008001, 2'b00, 2);
    do_op("sh",    1, 3'b001, 32'h62,  32'hFFFF1234, 1, 4'b1100, 32'h12341234, 32'h0,        1, 32'h0,        2'b00, 3);
    do_op("sh0",   1, 3'b001, 32'h60,  32'h00005678, 1, 4'b0011, 32'h56785678, 32'h0,        0, 32'h0,        2'b00, 2);
    do_op("sb3",   1, 3'b000, 32'h63,  32'h1234565A, 1, 4'b1000, 32'h5A5A5A5A, 32'h0,        0, 32'h0,        2'b00, 2);
    do_op("lb3",   0, 3'b000, 32'h63,  32'h0,        1, 4'b0000, 32'h0,        32'h80000000, 0, 32'hFFFFFF80, 2'b00, 2);
    do_op("lb0",   0, 3'b000, 32'h60,  32'h0,        1, 4'b0000, 32'h0,        32'h0000007F, 0, 32'h0000007F, 2'b00, 2);
    do_op("lh0",   0, 3'b001, 32'h60,  32'h0,        1, 4'b0000, 32'h0,        32'h1234F00D, 2, 32'hFFFFF00D, 2'b00, 4);
    do_op("lw mis",0, 3'b010, 32'h66,  32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        2'b01, 1);
    do_op("lh mis",0, 3'b001, 32'h61,  32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        2'b01, 1);
    do_op("sw mis",1, 3'b010, 32'h102, 32'h11111111, 0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        2'b01, 1);
    do_op("ld 011",0, 3'b011, 32'h64,  32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        2'b10, 1);
    do_op("ld 110",0, 3'b110, 32'h64,  32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        2'b10, 1);
    do_op("sh 101",1, 3'b101, 32'h62,  32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        2'b10, 1);
    do_op("sb 100",1, 3'b100, 32'h61,  32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        2'b10, 1);
    do_op("lw2",   0, 3'b010, 32'h68,  32'h0,        1, 4'b0000, 32'h0,        32'hCAFEF00D, 0, 32'hCAFEF00D, 2'b00, 2);

`ifdef LSU_TIMEOUT_EN
    do_op("timeout", 0, 3'b010, 32'h300, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 100000, 32'h0, 2'b11, 5);
    hang_cycles = 3;
`else
    hang_cycles = 40;
`endif

    // Unanswered load: core stays stalled until reset abandons the request.
    mem_q.push_back('{32'h200, 1'b0, 4'b0000, 32'h0, 32'h0, 100000});
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h200;
    n = 0;
    for (int c = 0; c < hang_cycles; c++) begin
      @(negedge clk);
      if (stall && mem_req === (c != 0) && !rsp_valid) n++;
    end
    check("hang stall cycles", n, hang_cycles);
    @(posedge clk);
    #3;
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("abort mem_req", {31'd0, mem_req}, 32'd0);
    check("abort stall", {31'd0, stall}, 32'd0);
    check("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    do_op("sw",    1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 32'h0,        2'b00, 2);
    do_op("lw100", 0, 3'b010, 32'h100, 32'h0,        1, 4'b0000, 32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 2'b00, 3);
    req_valid = 1'b0;

    repeat (4) @(negedge clk);
    check("held rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("pending rsp count", rsp_q.size(), 32'd0);
    check("pending mem count", mem_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
